pcpi_div_radix: RTL and testbench
=================================

# pcpi_div_radix

Parametrised iterative RISC-V M-extension divider on the PCPI coprocessor port. Executes DIV, DIVU, REM and REMU for a configurable operand width. It retires a configurable number of quotient bits per cycle. Divide-by-zero and signed-overflow cases finish on a one-cycle fast path and return the ISA-mandated results. It sits beside the PCPI multiplier and answers only the four divide/remainder encodings.

## Interface
Parameters:
- XLEN, 32, operand and result width; 32 or 64.
- BITS_PER_CYCLE, 1, quotient bits retired per CALC cycle; 1, 2 or 4; must divide XLEN.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low; clock clk.
- pcpi_valid  in  1  core presents an instruction.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  XLEN  dividend operand.
- pcpi_rs2  in  XLEN  divisor operand.
- pcpi_wr  out  1  result write-enable, pulses with pcpi_ready.
- pcpi_rd  out  XLEN  result; 0 whenever pcpi_ready is low.
- pcpi_wait  out  1  block owns the instruction and is computing.
- pcpi_ready  out  1  one-cycle completion strobe.

## Operation
- Decode: the instruction matches when opcode[6:0]=0110011, funct7=0000001 and funct3 is in 100..111 (DIV, DIVU, REM, REMU). All other instructions are ignored; no outputs change for them.
- FSM states:
  - IDLE -> CALC on a matching pcpi_valid while pcpi_ready=0, when neither special case applies.
  - IDLE -> DONE on a matching instruction that is a special case.
  - CALC -> DONE when the iteration counter reaches XLEN/BITS_PER_CYCLE.
  - DONE -> IDLE unconditionally.
- Accept (in IDLE):
  - Latch the operation.
  - Signed ops (DIV, REM) negate negative operands to their magnitudes.
  - Record the result sign: DIV uses sign(rs1) XOR sign(rs2); REM uses sign(rs1).
  - Clear the quotient, counter and partial remainder.
- Special cases, decided at accept:
  - Divisor 0: quotient = all ones; remainder = rs1 unchanged.
  - Signed overflow (DIV/REM, rs1 = -2^(XLEN-1), rs2 = -1): quotient = rs1; remainder = 0.
- CALC: radix-2^BITS_PER_CYCLE restoring division.
  - Each cycle chains BITS_PER_CYCLE shift/compare/subtract steps.
  - The partial remainder is XLEN+1 bits.
  - The quotient shifts in from the LSB side, MSB-first.
- DONE:
  - pcpi_ready=1 and pcpi_wr=1.
  - pcpi_rd = quotient for DIV/DIVU, remainder for REM/REMU.
  - The result is negated when the recorded sign is set, except on the special-case paths.
- pcpi_valid is not sampled in CALC or DONE. Operand changes after accept have no effect.
- Back-to-back: in the first IDLE cycle after DONE the core has already dropped valid. A new instruction is accepted in any IDLE cycle where pcpi_ready=0.

## Timing
- All outputs are registered.
- Reset values: pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0, state IDLE.
- Accept edge at cycle T:
  - Normal path: pcpi_wait=1 from T+1 through T+N, where N=XLEN/BITS_PER_CYCLE. pcpi_ready/pcpi_wr/pcpi_rd are valid in cycle T+N+1, with pcpi_wait=0.
  - Fast path: pcpi_wait stays 0 and pcpi_ready is high in cycle T+1.
- pcpi_ready is exactly one cycle wide and is never asserted with pcpi_wait.
- resetn low in any state: at the next edge, state is IDLE and all outputs return to reset values. The in-flight result is discarded and no ready is issued.
- Counter width is clog2(N+1). It must not wrap for XLEN=64, BITS_PER_CYCLE=1.

## Structure
- Package pcpi_div_pkg holds:
  - opcode/funct7/funct3 constants;
  - an operation enum (DIV, DIVU, REM, REMU);
  - the FSM state enum.
- Sub-module pcpi_div_step: one combinational restoring step (partial remainder, divisor -> new remainder, quotient bit). It is instantiated BITS_PER_CYCLE times in a generate chain.
- The top level holds the FSM, operand conditioning, counter and result sign fix-up.

## Test plan
- XLEN=32, B=1:
  - DIVU 100/7 -> rd=14 at T+33, wait high 32 cycles.
  - REMU 100/7 -> rd=2.
- XLEN=32, B=4: DIV -7/2 -> rd=-3 (0xFFFFFFFD) at T+9; REM -7/2 -> rd=-1.
- Divide by zero:
  - DIVU 5/0 -> rd=0xFFFFFFFF.
  - REM -5/0 -> rd=0xFFFFFFFB.
  - Both ready at T+1, wait never asserted.
- Signed overflow:
  - DIV 0x80000000/0xFFFFFFFF -> rd=0x80000000.
  - REM of the same operands -> rd=0.
  - Both on the fast path.
- Reset mid-CALC: resetn low at T+5 -> all outputs 0 next cycle, no ready. A following DIVU 9/3 completes normally with rd=3.
- Non-matching MUL insn (funct3=000) held valid 50 cycles -> wait and ready stay 0. XLEN=64, B=2 random sweep against a reference model, including rs2=1 and rs1=0.

Source files
------------

// File: rtl/pcpi_div_radix_pkg.sv
// Shared constants and types for the PCPI divide/remainder coprocessor.
// Holds the M-extension decode fields, the operation encoding and the FSM states.
package pcpi_div_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    function automatic logic is_div_insn(input logic [6:0] opcode,
                                         input logic [6:0] funct7,
                                         input logic [2:0] funct3);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) &&
               (funct3 inside {FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU});
    endfunction

    function automatic div_op_e op_from_funct3(input logic [2:0] funct3);
        div_op_e op;
        case (funct3)
            FUNCT3_DIV:  op = OP_DIV;
            FUNCT3_DIVU: op = OP_DIVU;
            FUNCT3_REM:  op = OP_REM;
            default:     op = OP_REMU;
        endcase
        return op;
    endfunction

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/pcpi_div_radix_if.sv
// PCPI coprocessor port bundle; the core is the master, the divider the slave.
interface pcpi_div_radix_if #(
    parameter int XLEN = 32
);
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/pcpi_div_radix_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it is non-negative and emit the quotient bit.
module pcpi_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN:0]   rem_out,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The incoming remainder is always below the divisor, so its top bit is zero.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_in[XLEN];

    assign shifted = {rem_in[XLEN-1:0], dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[XLEN];
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/pcpi_div_radix.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit on the PCPI port, retiring
// BITS_PER_CYCLE quotient bits per cycle with a one-cycle path for x/0 and overflow.
module pcpi_div_radix
    import pcpi_div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    pcpi_div_radix_if.slave  pcpi
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state, state_n;
    div_op_e         op_q;
    logic            neg_q;
    logic [XLEN-1:0] divisor_q, dividend_q, quo_q;
    logic [XLEN:0]   rem_q;
    logic [CW-1:0]   cnt_q;

    logic            wait_q, ready_q, wr_q;
    logic [XLEN-1:0] rd_q;
    logic            wait_n, ready_n;
    logic [XLEN-1:0] rd_n;

    // Decode and operand conditioning, all evaluated on the accept cycle.
    logic [2:0]      funct3;
    logic            match, accept;
    div_op_e         new_op;
    logic            new_signed, new_rem, new_neg;
    logic [XLEN-1:0] rs1, rs2, rs1_mag, rs2_mag, special_rd;
    logic            rs1_neg, rs2_neg, div_zero, overflow, special;

    logic unused_insn;
    assign unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

    assign funct3     = pcpi.pcpi_insn[14:12];
    assign match      = pcpi.pcpi_valid &&
                        is_div_insn(pcpi.pcpi_insn[6:0], pcpi.pcpi_insn[31:25], funct3);
    assign accept     = (state == ST_IDLE) && match && !ready_q;
    assign new_op     = op_from_funct3(funct3);
    assign new_signed = op_is_signed(new_op);
    assign new_rem    = op_is_rem(new_op);

    assign rs1        = pcpi.pcpi_rs1;
    assign rs2        = pcpi.pcpi_rs2;
    assign rs1_neg    = new_signed & rs1[XLEN-1];
    assign rs2_neg    = new_signed & rs2[XLEN-1];
    assign rs1_mag    = rs1_neg ? -rs1 : rs1;
    assign rs2_mag    = rs2_neg ? -rs2 : rs2;
    assign new_neg    = new_rem ? rs1_neg : (rs1_neg ^ rs2_neg);

    assign div_zero   = (rs2 == '0);
    assign overflow   = new_signed && (rs1 == MIN_INT) && (rs2 == '1);
    assign special    = div_zero || overflow;
    // ISA-mandated results: x/0 -> all ones rem x; MIN/-1 -> MIN rem 0.
    assign special_rd = new_rem ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);

    // Chain of restoring steps evaluated within one CALC cycle, MSB first.
    logic [XLEN:0]           rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        pcpi_div_step #(.XLEN(XLEN)) u_step (
            .rem_in       (rem_chain[i]),
            .divisor      (divisor_q),
            .dividend_bit (dividend_q[XLEN-1-i]),
            .rem_out      (rem_chain[i+1]),
            .q_bit        (q_bits[BITS_PER_CYCLE-1-i])
        );
    end

    logic [XLEN:0]   rem_next;
    logic [XLEN-1:0] quo_next, dividend_next, calc_base, calc_rd;
    logic            last_step;

    assign rem_next      = rem_chain[BITS_PER_CYCLE];
    assign quo_next      = {quo_q[XLEN-BITS_PER_CYCLE-1:0], q_bits};
    assign dividend_next = dividend_q << BITS_PER_CYCLE;
    assign last_step     = (cnt_q == CW'(N - 1));
    assign calc_base     = op_is_rem(op_q) ? rem_next[XLEN-1:0] : quo_next;
    assign calc_rd       = neg_q ? -calc_base : calc_base;

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        wait_n  = 1'b0;
        ready_n = 1'b0;
        rd_n    = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_n = ST_DONE;
                        ready_n = 1'b1;
                        rd_n    = special_rd;
                    end else begin
                        state_n = ST_CALC;
                        wait_n  = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (last_step) begin
                    state_n = ST_DONE;
                    ready_n = 1'b1;
                    rd_n    = calc_rd;
                end else begin
                    wait_n  = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            wait_q  <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state   <= state_n;
            wait_q  <= wait_n;
            ready_q <= ready_n;
            wr_q    <= ready_n;
            rd_q    <= rd_n;
        end
    end

    // NOTE: the datapath is deliberately not reset; it is fully loaded on accept
    // and never observed before then, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= new_op;
            neg_q      <= new_neg;
            divisor_q  <= rs2_mag;
            dividend_q <= rs1_mag;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else if (state == ST_CALC) begin
            quo_q      <= quo_next;
            rem_q      <= rem_next;
            dividend_q <= dividend_next;
            cnt_q      <= cnt_q + CW'(1);
        end
    end

    assign pcpi.pcpi_wait  = wait_q;
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = wr_q;
    assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_div_radix.sv
// Scoreboard bench for pcpi_div_radix: three configurations (32/B1, 32/B4, 64/B2)
// share one stimulus bus; per-instance monitors pop expectations on pcpi_ready.
module tb_pcpi_div_radix;

    localparam logic [2:0] F_MUL  = 3'b000;
    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] rd;
        int          t;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tb_valid = 1'b0;
    int          tb_sel = 0;
    logic [31:0] tb_insn = '0;
    logic [63:0] tb_rs1 = '0;
    logic [63:0] tb_rs2 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int waitcnt [3];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pcpi_div_radix_if #(.XLEN(32)) if1 ();
    pcpi_div_radix_if #(.XLEN(32)) if4 ();
    pcpi_div_radix_if #(.XLEN(64)) if64 ();

    assign if1.pcpi_valid  = tb_valid && (tb_sel == 0);
    assign if1.pcpi_insn   = tb_insn;
    assign if1.pcpi_rs1    = tb_rs1[31:0];
    assign if1.pcpi_rs2    = tb_rs2[31:0];
    assign if4.pcpi_valid  = tb_valid && (tb_sel == 1);
    assign if4.pcpi_insn   = tb_insn;
    assign if4.pcpi_rs1    = tb_rs1[31:0];
    assign if4.pcpi_rs2    = tb_rs2[31:0];
    assign if64.pcpi_valid = tb_valid && (tb_sel == 2);
    assign if64.pcpi_insn  = tb_insn;
    assign if64.pcpi_rs1   = tb_rs1;
    assign if64.pcpi_rs2   = tb_rs2;

    pcpi_div_radix #(.XLEN(32), .BITS_PER_CYCLE(1)) u_b1 (.clk(clk), .resetn(resetn), .pcpi(if1));
    pcpi_div_radix #(.XLEN(32), .BITS_PER_CYCLE(4)) u_b4 (.clk(clk), .resetn(resetn), .pcpi(if4));
    pcpi_div_radix #(.XLEN(64), .BITS_PER_CYCLE(2)) u_b64 (.clk(clk), .resetn(resetn), .pcpi(if64));

    logic sel_ready;
    assign sel_ready = (tb_sel == 0) ? if1.pcpi_ready :
                       (tb_sel == 1) ? if4.pcpi_ready : if64.pcpi_ready;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference model for the 64-bit sweep, built on SV's truncating / and %.
    function automatic logic [63:0] ref64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic ovf;
        ovf = (a == MIN64) && (b == '1);
        case (f3)
            F_DIV:   return (b == 0) ? '1 : ovf ? a : 64'($signed(a) / $signed(b));
            F_DIVU:  return (b == 0) ? '1 : a / b;
            F_REM:   return (b == 0) ? a  : ovf ? '0 : 64'($signed(a) % $signed(b));
            default: return (b == 0) ? a  : a % b;
        endcase
    endfunction

    task automatic push(input int s, input exp_t e);
        case (s)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int s, input logic r, input logic w, input logic wt, input logic [63:0] rd);
        exp_t e;
        int   qs;
        if (wt) waitcnt[s]++;
        if (r) begin
            qs = (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
            if (qs == 0) begin
                check($sformatf("spurious_ready_%0d", s), 64'(r), 64'd0);
            end else begin
                case (s)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                check($sformatf("rd_%0d", s), rd, e.rd);
                check($sformatf("wr_%0d", s), 64'(w), 64'd1);
                check($sformatf("ready_with_wait_%0d", s), 64'(wt), 64'd0);
                check($sformatf("latency_%0d", s), 64'(cyc), 64'(e.t));
                check($sformatf("wait_cycles_%0d", s), 64'(waitcnt[s]), 64'(e.waits));
            end
            waitcnt[s] = 0;
        end else if (rd != '0) begin
            check($sformatf("rd_not_zero_idle_%0d", s), rd, 64'd0);
        end
        if (!resetn) waitcnt[s] = 0;
    endtask

    always @(negedge clk) begin
        mon(0, if1.pcpi_ready, if1.pcpi_wr, if1.pcpi_wait, {32'h0, if1.pcpi_rd});
        mon(1, if4.pcpi_ready, if4.pcpi_wr, if4.pcpi_wait, {32'h0, if4.pcpi_rd});
        mon(2, if64.pcpi_ready, if64.pcpi_wr, if64.pcpi_wait, if64.pcpi_rd);
    end

    // Holds valid until ready like the core does, scrambling operands after accept.
    task automatic issue(input int s, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_rd, input bit fast);
        exp_t e;
        int   n;
        bit   seen;
        n = (s == 0) ? 32 : (s == 1) ? 8 : 32;
        @(negedge clk);
        tb_sel   = s;
        tb_insn  = mk_insn(f3);
        tb_rs1   = a;
        tb_rs2   = b;
        tb_valid = 1'b1;
        e.rd    = exp_rd;
        e.t     = cyc + 1 + (fast ? 0 : n);
        e.waits = fast ? 0 : n;
        push(s, e);
        @(posedge clk);
        #1;
        tb_rs1 = ~a;
        tb_rs2 = 64'h5;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = sel_ready;
        end
        check("ready_seen", 64'(seen), 64'd1);
        tb_valid = 1'b0;
    endtask

    task automatic issue64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        bit fast;
        fast = (b == 0) || (((f3 == F_DIV) || (f3 == F_REM)) && (a == MIN64) && (b == '1));
        issue(2, f3, a, b, ref64(f3, a, b), fast);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pa [12];
        logic [63:0] pb [12];
        logic [2:0]  ops [4];
        int          bad;
        waitcnt = '{0, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_wait_b1",   64'(if1.pcpi_wait),  64'd0);
        check("rst_ready_b1",  64'(if1.pcpi_ready), 64'd0);
        check("rst_wr_b4",     64'(if4.pcpi_wr),    64'd0);
        check("rst_rd_b64",    if64.pcpi_rd,        64'd0);
        resetn = 1'b1;

        // Normal path, 32-bit radix-2
        issue(0, F_DIVU, 64'd100, 64'd7, 64'd14, 1'b0);
        issue(0, F_REMU, 64'd100, 64'd7, 64'd2, 1'b0);
        // Normal path, 32-bit radix-16
        issue(1, F_DIV, 64'hFFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFD, 1'b0);
        issue(1, F_REM, 64'hFFFF_FFF9, 64'd2, 64'h0000_0000_FFFF_FFFF, 1'b0);
        issue(1, F_DIVU, 64'hFFFF_FFFF, 64'd16, 64'h0000_0000_0FFF_FFFF, 1'b0);
        // Divide by zero and signed overflow take the fast path
        issue(0, F_DIVU, 64'd5, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b1);
        issue(0, F_REM, 64'hFFFF_FFFB, 64'd0, 64'h0000_0000_FFFF_FFFB, 1'b1);
        issue(0, F_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        issue(1, F_REM, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b1);
        // Unsigned ops with the same operands are not overflow
        issue(1, F_DIVU, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b0);

        // Reset in the middle of CALC discards the result
        @(negedge clk);
        tb_sel   = 0;
        tb_insn  = mk_insn(F_DIVU);
        tb_rs1   = 64'd9;
        tb_rs2   = 64'd3;
        tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("calc_wait_before_rst", 64'(if1.pcpi_wait), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_wait",  64'(if1.pcpi_wait),  64'd0);
        check("midrst_ready", 64'(if1.pcpi_ready), 64'd0);
        check("midrst_wr",    64'(if1.pcpi_wr),    64'd0);
        check("midrst_rd",    64'(if1.pcpi_rd),    64'd0);
        resetn = 1'b1;
        issue(0, F_DIVU, 64'd9, 64'd3, 64'd3, 1'b0);

        // Non-matching MUL held valid must be ignored
        @(negedge clk);
        tb_sel   = 0;
        tb_insn  = mk_insn(F_MUL);
        tb_rs1   = 64'd10;
        tb_rs2   = 64'd3;
        tb_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (if1.pcpi_wait || if1.pcpi_ready) bad++;
        end
        tb_valid = 1'b0;
        check("mul_ignored", 64'(bad), 64'd0);

        // 64-bit radix-4 sweep against the reference model
        pa = '{64'd0, 64'd123456789, 64'hFFFF_FFFF_FFFF_FC18, MIN64, MIN64,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'd0, 64'd0, 64'd0};
        pb = '{64'd7, 64'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'd0, 64'h0001_2345, 64'hFFFF_FFFF_FFFF_FFFE,
               64'd0, 64'd0, 64'd0, 64'd0};
        for (int i = 8; i < 12; i++) begin
            pa[i] = {$urandom, $urandom};
            pb[i] = (i == 11) ? {$urandom, $urandom} | 64'd1 : 64'($urandom_range(1, 1000));
        end
        ops = '{F_DIV, F_DIVU, F_REM, F_REMU};
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 4; j++)
                issue64(ops[j], pa[i], pb[i]);

        repeat (3) @(negedge clk);
        check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
